// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared types and constants for the ARK fetch stage
package instr_fetch_pkg;
  localparam int kOPCODE_W = 4;
  localparam logic [kOPCODE_W-1:0] kOP_HALT = 4'd15;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALTED} fetch_state_t;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: ARK fetch stage, owns the PC and keeps at most one imem request in flight
// Ports: i_clk/i_rst_n (async active-low reset), i_start/i_start_pc launch fetching,
//   o_imem_req/o_imem_addr + i_imem_rvalid/i_imem_rdata talk to instruction memory,
//   o_instr/o_opcode/o_pc/o_instr_valid + i_instr_ready hand instructions to Control,
//   i_halt stops fetching on handshake, i_redirect/i_redirect_pc flush and refetch,
//   o_halted flags the stopped state. With FETCH_COUNT_EN defined, o_fetch_count
//   counts accepted instructions (saturating, cleared by reset and honoured start).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [PC_W-1:0]      i_start_pc,
  output logic                 o_imem_req,
  output logic [PC_W-1:0]      o_imem_addr,
  input  logic                 i_imem_rvalid,
  input  logic [INSTR_W-1:0]   i_imem_rdata,
  output logic [INSTR_W-1:0]   o_instr,
  output logic [kOPCODE_W-1:0] o_opcode,
  output logic [PC_W-1:0]      o_pc,
  output logic                 o_instr_valid,
  input  logic                 i_instr_ready,
  input  logic                 i_halt,
  input  logic                 i_redirect,
  input  logic [PC_W-1:0]      i_redirect_pc,
`ifdef FETCH_COUNT_EN
  output logic [15:0]          o_fetch_count,
`endif
  output logic                 o_halted
);
  fetch_state_t       r_state, w_state;
  logic [PC_W-1:0]    r_pc, w_pc;
  logic [INSTR_W-1:0] r_instr, w_instr;
  logic               r_drop, w_drop;
  logic               w_hs, w_start_ok, w_redir;
  assign w_hs       = (r_state == HOLD) && i_instr_ready;
  assign w_start_ok = i_start && (r_state == IDLE || r_state == HALTED);
  assign w_redir    = i_redirect && (r_state == REQ || r_state == WAIT || r_state == HOLD);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_instr <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_instr <= w_instr;
      r_drop  <= w_drop;
    end
  end
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_instr = r_instr;
    w_drop  = r_drop;
    case (r_state)
      IDLE, HALTED: if (w_start_ok) begin
        w_state = REQ;
        w_pc    = i_start_pc;
        w_drop  = 1'b0;
      end
      REQ: w_state = WAIT;
      WAIT: if (i_imem_rvalid) begin
        w_state = (r_drop || i_redirect) ? REQ : HOLD;
        w_instr = (r_drop || i_redirect) ? r_instr : i_imem_rdata;
        w_drop  = 1'b0;
      end
      HOLD: if (w_hs) begin
        w_state = i_halt ? HALTED : REQ;
        w_pc    = i_halt ? r_pc : r_pc + 1'b1;
      end
      default: w_state = IDLE;
    endcase
    // A redirect overrides halt and handshake; if the in-flight response has
    // not arrived yet, wait for it and throw it away before refetching.
    if (w_redir) begin
      w_pc    = i_redirect_pc;
      w_state = (r_state == HOLD || (r_state == WAIT && i_imem_rvalid)) ? REQ : WAIT;
      w_drop  = (w_state == WAIT);
    end
  end
  assign o_imem_req    = (r_state == REQ);
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_opcode      = r_instr[INSTR_W-1 -: kOPCODE_W];
  assign o_pc          = r_pc;
  assign o_instr_valid = (r_state == HOLD);
  assign o_halted      = (r_state == HALTED);
`ifdef FETCH_COUNT_EN
  logic [15:0] r_count;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_count <= '0;
    else if (w_start_ok) r_count <= '0;
    else if (w_hs && !w_redir && r_count != 16'hFFFF) r_count <= r_count + 1'b1;
  end
  assign o_fetch_count = r_count;
`endif
endmodule
